abc_stimulus_gen: RTL and testbench
===================================

Name: abc_stimulus_gen

Overview:
Upstream stimulus sequencer for the three-input gate circuit (inputs A, B, C; outputs D, E). On a start request it drives all 8 input vectors in binary or Gray order. Each vector is held for a programmable settle time, then D/E are sampled into a packed result word. It sits directly in front of the gate circuit and closes the loop by capturing its outputs, so a clocked bench or top level can sweep the circuit's truth table.

Parameters:
HOLD_CYCLES, 10, settle cycles each vector is held before sampling; legal range 1..2**CNT_W.
CNT_W, 8, width of the hold counter; must hold HOLD_CYCLES-1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  sweep request; sampled only in IDLE
gray_mode  input  1  0 = binary order, 1 = Gray order; latched when start is accepted
A  output  1  stimulus bit 2 of current vector
B  output  1  stimulus bit 1
C  output  1  stimulus bit 0
D  input  1  circuit output D
E  input  1  circuit output E
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the sweep completes
vec_idx  output  3  sweep step index 0..7
sample_valid  output  1  one-cycle pulse in each SAMPLE cycle
results  output  16  results[2i+1:2i] = {D,E} sampled for step i
mismatch  output  1  sticky self-check error (feature only)
mismatch_count  output  4  self-check error count (feature only)

Behaviour:
- Reset (asynchronous, immediate): A=B=C=0, busy=0, done=0, sample_valid=0, vec_idx=0, results=0, mismatch=0, mismatch_count=0, FSM=IDLE.
- FSM states are IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - A/B/C=000.
  - On start=1: clear results, set idx=0, latch gray_mode, drive vector(0), go to WAIT.
- Vector mapping: vec = idx in binary mode, or idx^(idx>>1) in Gray mode; {A,B,C} = vec.
- WAIT:
  - Hold counter runs 0..HOLD_CYCLES-1, so WAIT lasts exactly HOLD_CYCLES cycles.
  - At terminal count, go to SAMPLE.
- SAMPLE (1 cycle):
  - Register {D,E} into results[2*idx+1:2*idx]; sample_valid=1.
  - If idx==7, go to DONE. Otherwise idx+1, drive the new vector on the next edge, counter=0, go to WAIT.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Latency:
  - Each step occupies HOLD_CYCLES+1 cycles.
  - With start accepted at edge 0, done is high in cycle 1+8*(HOLD_CYCLES+1). For HOLD_CYCLES=10 that is cycle 89.
- start outside IDLE is ignored, including during DONE.
- start held high continuously: the next sweep begins with the IDLE cycle following DONE.
- results hold their value after DONE until the next accepted start.
- gray_mode changes mid-sweep have no effect.
- Reset mid-sweep aborts immediately: no done pulse, results cleared.
- D/E are not synchronised; the settle time covers the circuit's propagation delay.

Optional Feature:
ABC_SELFCHECK_EN:
- Defined: in each SAMPLE, compare D against (A&B)|~C and E against ~C.
  - Any difference sets mismatch (sticky until the next start or reset).
  - Any difference increments mismatch_count, saturating at 15.
- Undefined: mismatch and mismatch_count ports remain present and are tied to 0; no compare logic.

Decomposition:
- Package abc_stim_pkg contains:
  - state enum (IDLE, WAIT, SAMPLE, DONE)
  - constants VEC_COUNT=8 and RES_W=16
  - function to_gray(idx)
- One sub-module, abc_hold_timer: counter with load/enable and terminal-count output, parameterised by CNT_W and HOLD_CYCLES.

Test Plan:
1. Reset: hold rst_n=0 with start=1 → A/B/C=000, busy=0, done=0, results=16'h0000. Deassert rst_n → remains IDLE until start is sampled.
2. Binary sweep, HOLD_CYCLES=10, ideal circuit model: start pulse at cycle 0 → done at cycle 89, 8 sample_valid pulses, results=16'hB333.
3. Gray sweep: gray_mode=1 at start → A/B/C order 000,001,011,010,110,111,101,100, results=16'hCBC3.
4. start pulsed at cycle 30 (during busy) → ignored, a single done at 89. start held high → second sweep's busy rises at cycle 91.
5. rst_n low at cycle 40 → outputs return to reset values immediately; no done pulse.
6. ABC_SELFCHECK_EN defined, model forces D=0 for vector 111 → mismatch=1, mismatch_count=1, results=16'h3333. Same run without the macro → mismatch=0.

Source files
------------

// File: rtl/abc_stim_pkg.sv
// Shared types and helpers for the ABC gate-circuit stimulus sequencer.
package abc_stim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int VEC_COUNT = 8;
  localparam int RES_W     = 16;

  function automatic logic [2:0] to_gray(input logic [2:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/abc_hold_timer.sv
// Settle-time counter: load clears to 0, enable counts up, tc_o flags HOLD_CYCLES-1.
module abc_hold_timer #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/abc_stimulus_gen.sv
// Sweeps all 8 {A,B,C} vectors (binary or Gray), holds each HOLD_CYCLES, then captures {D,E}.
// Optional ABC_SELFCHECK_EN compares captured outputs against D=(A&B)|~C, E=~C.
module abc_stimulus_gen
  import abc_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gray_mode,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             D,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic [2:0]       vec_idx,
  output logic             sample_valid,
  output logic [RES_W-1:0] results,
  output logic             mismatch,
  output logic [3:0]       mismatch_count
);

  localparam logic [2:0] LAST_IDX = 3'(VEC_COUNT - 1);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic             gray_q;
  logic [2:0]       abc_q;
  logic             busy_q;
  logic             done_q;
  logic             sv_q;
  logic [RES_W-1:0] results_q;
  logic             tc;
  logic             accept;

  function automatic logic [2:0] vec_of(input logic [2:0] i, input logic g);
    return g ? to_gray(i) : i;
  endfunction

  assign accept = (state_q == IDLE) && start;
  assign idx_d  = idx_q + 3'd1;

  abc_hold_timer #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept || (state_q == SAMPLE)),
    .en_i   ((state_q == WAIT) && !tc),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gray_q    <= 1'b0;
      abc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sv_q      <= 1'b0;
      results_q <= '0;
    end else begin
      done_q <= 1'b0;
      sv_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          abc_q <= '0;
          if (start) begin
            results_q <= '0;
            idx_q     <= '0;
            gray_q    <= gray_mode;
            abc_q     <= vec_of(3'd0, gray_mode);
            busy_q    <= 1'b1;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (tc) begin
            sv_q    <= 1'b1;
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          results_q[{idx_q, 1'b0} +: 2] <= {D, E};
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
            abc_q   <= vec_of(idx_d, gray_q);
            state_q <= WAIT;
          end
        end
        DONE: begin
          abc_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {A, B, C}    = abc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vec_idx      = idx_q;
  assign sample_valid = sv_q;
  assign results      = results_q;

`ifdef ABC_SELFCHECK_EN
  logic       mis_q;
  logic [3:0] mcnt_q;
  logic       err;

  // abc_q is the vector the circuit has been settling on, so it is the reference input.
  assign err = (D != ((abc_q[2] & abc_q[1]) | ~abc_q[0])) || (E != ~abc_q[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q  <= 1'b0;
      mcnt_q <= '0;
    end else if (accept) begin
      mis_q  <= 1'b0;
      mcnt_q <= '0;
    end else if ((state_q == SAMPLE) && err) begin
      mis_q <= 1'b1;
      if (mcnt_q != 4'd15) begin
        mcnt_q <= mcnt_q + 4'd1;
      end
    end
  end

  assign mismatch       = mis_q;
  assign mismatch_count = mcnt_q;
`else
  assign mismatch       = 1'b0;
  assign mismatch_count = 4'd0;
`endif

endmodule

// File: tb/tb_abc_stimulus_gen.sv
// Scoreboard bench for abc_stimulus_gen driving an ideal (or faulted) model of the gate circuit.
module tb_abc_stimulus_gen;

  localparam int H        = 10;
  localparam int DONE_LAT = 1 + 8 * (H + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gray_mode = 1'b0;
  logic        fault_en = 1'b0;
  logic        A, B, C, D, E;
  logic        busy, done, sample_valid, mismatch;
  logic [2:0]  vec_idx;
  logic [15:0] results;
  logic [3:0]  mismatch_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] vec;
  } smp_t;

  typedef struct {
    logic [15:0] res;
    int          at;
  } dexp_t;

  smp_t       smp_q[$];
  dexp_t      dexp_q[$];
  logic [2:0] gray_tab[8];
  logic       exp_mis;
  logic [3:0] exp_cnt;

  abc_stimulus_gen #(
    .HOLD_CYCLES (H),
    .CNT_W       (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .gray_mode      (gray_mode),
    .A              (A),
    .B              (B),
    .C              (C),
    .D              (D),
    .E              (E),
    .busy           (busy),
    .done           (done),
    .vec_idx        (vec_idx),
    .sample_valid   (sample_valid),
    .results        (results),
    .mismatch       (mismatch),
    .mismatch_count (mismatch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Gate circuit model; fault_en sticks D low for vector 111.
  assign D = (fault_en && A && B && C) ? 1'b0 : ((A & B) | ~C);
  assign E = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input int pending);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen with %0d entries pending, expected at least 1", name, pending);
  endtask

  task automatic expect_sweep(input int c0, input logic g, input logic [15:0] res);
    dexp_t d;
    for (int i = 0; i < 8; i++) begin
      smp_t s;
      s.idx = 3'(i);
      s.vec = g ? gray_tab[i] : 3'(i);
      smp_q.push_back(s);
    end
    d.res = res;
    d.at  = c0 + DONE_LAT;
    dexp_q.push_back(d);
  endtask

  task automatic issue(input logic g, input logic [15:0] res, output int c0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    gray_mode = g;
    c0        = cyc;
    expect_sweep(c0, g, res);
    @(posedge clk);
    #1;
    start     = 1'b0;
    gray_mode = ~g;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int n;
    d0 = done_seen;
    n  = 0;
    while (done_seen == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (done_seen == d0) begin
      chk("done timeout", 32'(done_seen), 32'(d0 + 1));
    end
    chk("samples left over", 32'(smp_q.size()), 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a sample or a done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid) begin
        if (smp_q.size() == 0) begin
          spurious("sample_valid", smp_q.size());
        end else begin
          smp_t s;
          s = smp_q.pop_front();
          chk("sample vec_idx", 32'(vec_idx), 32'(s.idx));
          chk("sample ABC", 32'({A, B, C}), 32'(s.vec));
        end
      end
      if (done) begin
        done_seen++;
        if (dexp_q.size() == 0) begin
          spurious("done", dexp_q.size());
        end else begin
          dexp_t d;
          d = dexp_q.pop_front();
          chk("done cycle", 32'(cyc), 32'(d.at));
          chk("results", 32'(results), 32'(d.res));
          chk("busy at done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`ifdef ABC_SELFCHECK_EN
    exp_mis = 1'b1;
    exp_cnt = 4'd1;
`else
    exp_mis = 1'b0;
    exp_cnt = 4'd0;
`endif

    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ABC", 32'({A, B, C}), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset results", 32'(results), 32'h0);
    chk("reset vec_idx", 32'(vec_idx), 32'd0);
    chk("reset mismatch", 32'(mismatch), 32'd0);
    chk("reset mismatch_count", 32'(mismatch_count), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle sample_valid", 32'(sample_valid), 32'd0);

    // Binary sweep.
    issue(1'b0, 16'hB333, c0);
    wait_done(200);
    repeat (5) @(negedge clk);
    chk("results hold", 32'(results), 32'hB333);
    chk("clean mismatch", 32'(mismatch), 32'd0);

    // Gray sweep; gray_mode is flipped right after start by issue().
    issue(1'b1, 16'hCBC3, c0);
    wait_done(200);

    // start pulse at cycle 30 of a running sweep is ignored.
    issue(1'b0, 16'hB333, c0);
    while (cyc < c0 + 30) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // start held high: second sweep starts in the IDLE cycle after DONE.
    @(posedge clk);
    #1;
    start     = 1'b1;
    gray_mode = 1'b0;
    c0        = cyc;
    expect_sweep(c0, 1'b0, 16'hB333);
    expect_sweep(c0 + DONE_LAT + 1, 1'b0, 16'hB333);
    while (cyc < c0 + DONE_LAT + 1) @(negedge clk);
    chk("busy in IDLE between sweeps", 32'(busy), 32'd0);
    @(negedge clk);
    chk("busy rises for second sweep", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // Reset in the middle of a sweep.
    issue(1'b0, 16'hB333, c0);
    while (cyc < c0 + 40) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ABC", 32'({A, B, C}), 32'd0);
    chk("abort results", 32'(results), 32'h0);
    chk("abort vec_idx", 32'(vec_idx), 32'd0);
    smp_q.delete();
    dexp_q.delete();
    d0 = done_seen;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("no done after abort", 32'(done_seen), 32'(d0));

    // Faulty circuit: D stuck low for vector 111.
    fault_en = 1'b1;
    issue(1'b0, 16'h3333, c0);
    wait_done(200);
    chk("fault mismatch", 32'(mismatch), 32'(exp_mis));
    chk("fault mismatch_count", 32'(mismatch_count), 32'(exp_cnt));
    fault_en = 1'b0;
    issue(1'b0, 16'hB333, c0);
    wait_done(200);
    chk("mismatch cleared by start", 32'(mismatch), 32'd0);
    chk("mismatch_count cleared", 32'(mismatch_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
